mux_ex: RTL and testbench
=========================

Name: mux_ex

Overview:
- Parameterised 4-to-1 word multiplexer. A 2-bit select routes one of four data words (A, B, C, D) to output Y.
- Y is combinational, so a select change is visible in the same cycle.
- A registered copy of the output, plus a registered change strobe, is also provided for downstream clocked logic.
- Used as a general datapath selector (operand/result steering).

Parameters:
- WIDTH, default 4, bit width of each data input and of the data outputs.
- RESET_VAL, default 0, value loaded into Y_q on reset (WIDTH bits).

Ports:
- clk  input  1  rising-edge clock for the registered outputs.
- rst_n  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- sel  input  2  select: 0 picks A, 1 picks B, 2 picks C, 3 picks D.
- A  input  WIDTH  data word 0.
- B  input  WIDTH  data word 1.
- C  input  WIDTH  data word 2.
- D  input  WIDTH  data word 3.
- Y  output  WIDTH  combinational selected word.
- Y_q  output  WIDTH  registered selected word.
- sel_q  output  2  registered select value.
- chg  output  1  registered strobe: high for one cycle after Y_q changes value.

Behaviour:
- Y = A when sel=0, B when sel=1, C when sel=2, D when sel=3.
  - Purely combinational, zero cycles of latency.
  - No dependence on clk or rst_n; Y stays valid during reset.
- All four sel codes are decoded explicitly. There is no default or latch path, and no X is generated for legal sel values.
- Registered path, on each rising edge of clk:
  - If rst_n=0: Y_q <= RESET_VAL, sel_q <= 0, chg <= 0.
  - Otherwise: Y_q <= Y, sel_q <= sel, and chg <= 1 if Y differs from the current Y_q, else 0.
- Latency:
  - Y_q and sel_q lag Y and sel by exactly one cycle.
  - chg is asserted in the same cycle that the new Y_q appears.
- Data change with sel unchanged: Y follows the newly selected input immediately; Y_q follows on the next edge.
- Selecting two inputs that hold equal values gives no chg pulse, because chg compares data, not select.
- Reset asserted mid-operation: the registered outputs return to their reset values on the next edge, whatever the state of sel or the data inputs. Y is unaffected.
- Reset deasserted: the first active edge loads the current Y into Y_q. chg=1 on that edge if Y differs from RESET_VAL.
- Width rules: no arithmetic. All data paths are exactly WIDTH bits, with no extension or truncation.
- No internal state besides Y_q, sel_q and chg.

Test Plan:
- Combinational sweep. Hold A=4'h0, B=4'h4, C=4'hA, D=4'h7 and step sel 0,1,2,3 at 20 ns intervals.
  - Expect Y = 0, 4, A, 7 respectively, settled before each next step.
- Registered latency. With rst_n=1, change sel from 0 to 2 one ns after an edge.
  - Expect Y=4'hA immediately.
  - Expect Y_q=4'hA and sel_q=2 after the next rising edge.
  - Expect chg=1 for exactly one cycle, then 0.
- Synchronous reset.
  - Hold rst_n=0 over two edges with sel=3: expect Y_q=RESET_VAL, sel_q=0, chg=0, while Y=4'h7 throughout.
  - Release rst_n: expect Y_q=4'h7 and chg=1 after the first edge.
- Data change without select change. With sel=1, change B from 4 to 4'hF.
  - Expect Y=F immediately, and Y_q=F with chg=1 after one edge.
- Equal-data select. Set A=B=4'h5 and switch sel from 0 to 1.
  - Expect Y=5 throughout, Y_q unchanged at 5, and chg stays 0.
- Reset mid-sweep. Assert rst_n=0 for one cycle during the sel sweep.
  - Expect the registered outputs to clear on that edge and resume tracking Y on the following edge, with Y uninterrupted.

Source files
------------

// File: rtl/mux_ex.sv
// mux_ex: 4-to-1 word multiplexer with a combinational output and a
// registered copy (data, select and a one-cycle change strobe) for
// downstream clocked logic.
module mux_ex #(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Y,
  output logic [WIDTH-1:0] Y_q,
  output logic [1:0]       sel_q,
  output logic             chg
);

  // Route the selected word straight to Y; every sel code has its own arm, so there is no fall-through
  always_comb begin
    case (sel)
      2'd0: Y = A;
      2'd1: Y = B;
      2'd2: Y = C;
      2'd3: Y = D;
    endcase
  end

  // Register the selected word and select, and flag when the registered word takes a new value
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      Y_q   <= RESET_VAL;
      sel_q <= 2'd0;
      chg   <= 1'b0;
    end else begin
      Y_q   <= Y;
      sel_q <= sel;
      chg   <= (Y != Y_q);
    end
  end

endmodule

// File: tb/tb_mux_ex.sv
// tb_mux_ex: directed-vector bench for mux_ex with a queue-based scoreboard.
// Each vector is driven 1 ns after a rising edge and carries the values
// expected at the following falling edge: Y for the vector's own inputs,
// and Y_q/sel_q/chg as left by the rising edge that preceded it.
module tb_mux_ex;

  localparam int WIDTH = 4;

  typedef struct {
    int         row;
    logic [3:0] y;
    logic [3:0] yq;
    logic [1:0] selq;
    logic       chg;
  } expect_t;

  logic             clk;
  logic             rst_n;
  logic [1:0]       sel;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] C;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] Y;
  logic [WIDTH-1:0] Y_q;
  logic [1:0]       sel_q;
  logic             chg;

  expect_t expQ[$];
  int      compared   = 0;
  int      mismatched = 0;
  int      rowCount   = 0;

  mux_ex #(
    .WIDTH    (WIDTH),
    .RESET_VAL(4'h0)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .sel  (sel),
    .A    (A),
    .B    (B),
    .C    (C),
    .D    (D),
    .Y    (Y),
    .Y_q  (Y_q),
    .sel_q(sel_q),
    .chg  (chg)
  );

  // 20 ns clock period
  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Compare one observed value against its expectation and log a failure
  task automatic checkOutput(input string name, input int row,
                             input logic [3:0] act, input logic [3:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  // Drive one vector after a rising edge and queue what it should produce
  task automatic applyStimulus(input logic r, input logic [1:0] s,
                               input logic [3:0] a, input logic [3:0] b,
                               input logic [3:0] c, input logic [3:0] d,
                               input logic [3:0] expY, input logic [3:0] expYq,
                               input logic [1:0] expSelq, input logic expChg);
    expect_t e;
    @(posedge clk);
    #1;
    rst_n = r;
    sel   = s;
    A     = a;
    B     = b;
    C     = c;
    D     = d;
    e.row  = rowCount;
    e.y    = expY;
    e.yq   = expYq;
    e.selq = expSelq;
    e.chg  = expChg;
    expQ.push_back(e);
    rowCount++;
  endtask

  // Monitor: on every falling edge, pop the pending expectation and compare all outputs
  initial begin
    expect_t e;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("Y",     e.row, Y,              e.y);
        checkOutput("Y_q",   e.row, Y_q,            e.yq);
        checkOutput("sel_q", e.row, {2'b00, sel_q}, {2'b00, e.selq});
        checkOutput("chg",   e.row, {3'b000, chg},  {3'b000, e.chg});
      end
    end
  end

  // Directed vectors: rst_n, sel, A, B, C, D, then expected Y, Y_q, sel_q, chg
  initial begin
    rst_n = 1'b0;
    sel   = 2'd0;
    A     = 4'h0;
    B     = 4'h4;
    C     = 4'hA;
    D     = 4'h7;

    // reset held over several edges with sel=3, Y live throughout
    applyStimulus(0, 2'd0, 4'h0, 4'h4, 4'hA, 4'h7, 4'h0, 4'h0, 2'd0, 0);
    applyStimulus(0, 2'd3, 4'h0, 4'h4, 4'hA, 4'h7, 4'h7, 4'h0, 2'd0, 0);
    applyStimulus(0, 2'd3, 4'h0, 4'h4, 4'hA, 4'h7, 4'h7, 4'h0, 2'd0, 0);
    // release: first edge loads 7 with a strobe
    applyStimulus(1, 2'd3, 4'h0, 4'h4, 4'hA, 4'h7, 4'h7, 4'h0, 2'd0, 0);
    applyStimulus(1, 2'd0, 4'h0, 4'h4, 4'hA, 4'h7, 4'h0, 4'h7, 2'd3, 1);
    applyStimulus(1, 2'd0, 4'h0, 4'h4, 4'hA, 4'h7, 4'h0, 4'h0, 2'd0, 1);
    applyStimulus(1, 2'd0, 4'h0, 4'h4, 4'hA, 4'h7, 4'h0, 4'h0, 2'd0, 0);
    // select sweep
    applyStimulus(1, 2'd1, 4'h0, 4'h4, 4'hA, 4'h7, 4'h4, 4'h0, 2'd0, 0);
    applyStimulus(1, 2'd2, 4'h0, 4'h4, 4'hA, 4'h7, 4'hA, 4'h4, 2'd1, 1);
    applyStimulus(1, 2'd2, 4'h0, 4'h4, 4'hA, 4'h7, 4'hA, 4'hA, 2'd2, 1);
    applyStimulus(1, 2'd2, 4'h0, 4'h4, 4'hA, 4'h7, 4'hA, 4'hA, 2'd2, 0);
    applyStimulus(1, 2'd3, 4'h0, 4'h4, 4'hA, 4'h7, 4'h7, 4'hA, 2'd2, 0);
    applyStimulus(1, 2'd3, 4'h0, 4'h4, 4'hA, 4'h7, 4'h7, 4'h7, 2'd3, 1);
    // sel 0 -> 2: one-cycle latency and a single chg pulse
    applyStimulus(1, 2'd0, 4'h0, 4'h4, 4'hA, 4'h7, 4'h0, 4'h7, 2'd3, 0);
    applyStimulus(1, 2'd2, 4'h0, 4'h4, 4'hA, 4'h7, 4'hA, 4'h0, 2'd0, 1);
    applyStimulus(1, 2'd2, 4'h0, 4'h4, 4'hA, 4'h7, 4'hA, 4'hA, 2'd2, 1);
    applyStimulus(1, 2'd2, 4'h0, 4'h4, 4'hA, 4'h7, 4'hA, 4'hA, 2'd2, 0);
    // data change on B with sel held at 1
    applyStimulus(1, 2'd1, 4'h0, 4'h4, 4'hA, 4'h7, 4'h4, 4'hA, 2'd2, 0);
    applyStimulus(1, 2'd1, 4'h0, 4'hF, 4'hA, 4'h7, 4'hF, 4'h4, 2'd1, 1);
    applyStimulus(1, 2'd1, 4'h0, 4'hF, 4'hA, 4'h7, 4'hF, 4'hF, 2'd1, 1);
    applyStimulus(1, 2'd1, 4'h0, 4'hF, 4'hA, 4'h7, 4'hF, 4'hF, 2'd1, 0);
    // equal data on A and B: select moves, chg stays low
    applyStimulus(1, 2'd0, 4'h5, 4'h5, 4'hA, 4'h7, 4'h5, 4'hF, 2'd1, 0);
    applyStimulus(1, 2'd0, 4'h5, 4'h5, 4'hA, 4'h7, 4'h5, 4'h5, 2'd0, 1);
    applyStimulus(1, 2'd1, 4'h5, 4'h5, 4'hA, 4'h7, 4'h5, 4'h5, 2'd0, 0);
    applyStimulus(1, 2'd1, 4'h5, 4'h5, 4'hA, 4'h7, 4'h5, 4'h5, 2'd1, 0);
    // one-cycle reset in the middle of a sweep
    applyStimulus(1, 2'd0, 4'h0, 4'h4, 4'hA, 4'h7, 4'h0, 4'h5, 2'd1, 0);
    applyStimulus(1, 2'd1, 4'h0, 4'h4, 4'hA, 4'h7, 4'h4, 4'h0, 2'd0, 1);
    applyStimulus(0, 2'd2, 4'h0, 4'h4, 4'hA, 4'h7, 4'hA, 4'h4, 2'd1, 1);
    applyStimulus(1, 2'd3, 4'h0, 4'h4, 4'hA, 4'h7, 4'h7, 4'h0, 2'd0, 0);
    applyStimulus(1, 2'd3, 4'h0, 4'h4, 4'hA, 4'h7, 4'h7, 4'h7, 2'd3, 1);
    applyStimulus(1, 2'd0, 4'h0, 4'h4, 4'hA, 4'h7, 4'h0, 4'h7, 2'd3, 0);

    // let the monitor drain the queue, bounded to a few cycles
    for (int i = 0; i < 5 && expQ.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    if (expQ.size() > 0) begin
      mismatched++;
      $display("[TB] FAIL drain: %0d expectations left, required 0", expQ.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
